// File: rtl/cnt_mod_n.sv
// Modulo-MOD up/down counter with enable, clear, load, and wrap or saturate mode.
// It also provides a terminal-count pulse, a sticky load error flag and a registered Gray-code output.
module cnt_mod_n #(
    parameter int MOD       = 5,
    parameter int WIDTH     = 3,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             inc,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             err
);

    // Bounds are compared before any arithmetic is done.
    // As a result, MOD = 2^WIDTH cannot overflow the register.
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        err_d = err_q;
        if (clr) begin
            cnt_d = RST_V;
            err_d = 1'b0;
        end else if (load) begin
            if (load_val <= MAX_V) begin
                cnt_d = load_val;
            end else begin
                cnt_d = MAX_V;
                err_d = 1'b1;
            end
        end else if (en) begin
            if (inc) begin
                if (cnt_q == MAX_V) begin
                    tc_d = 1'b1;
                    if (!sat) cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + ONE_V;
                end
            end else begin
                if (cnt_q == '0) begin
                    tc_d = 1'b1;
                    if (!sat) cnt_d = MAX_V;
                end else begin
                    cnt_d = cnt_q - ONE_V;
                end
            end
        end
        gray_d = cnt_d ^ (cnt_d >> 1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= RST_V;
            gray_q <= RST_V ^ (RST_V >> 1);
            tc_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
            err_q  <= err_d;
        end
    end

    assign cnt  = cnt_q;
    assign gray = gray_q;
    assign tc   = tc_q;
    assign err  = err_q;

endmodule

// File: tb/tb_cnt_mod_n.sv
// Directed bench for cnt_mod_n (MOD=5, WIDTH=3).
// The driver queues hand-computed {cnt,gray,tc,err} values, and a monitor pops and compares them after each edge.
module tb_cnt_mod_n;
    localparam int W = 3;

    logic         clk;
    logic         reset_n;
    logic         en, inc, sat, clr, load;
    logic [W-1:0] load_val;
    logic [W-1:0] cnt, gray;
    logic         tc, err;

    logic [2*W+1:0] exp_q[$];
    int           n_vec;
    int           n_miss;
    event         async_ev;

    cnt_mod_n #(.MOD(5), .WIDTH(W), .RESET_VAL(0)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .inc(inc), .sat(sat),
        .clr(clr), .load(load), .load_val(load_val),
        .cnt(cnt), .gray(gray), .tc(tc), .err(err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] gray_of(input logic [W-1:0] v);
        return v ^ (v >> 1);
    endfunction

    // Driver: present inputs mid-cycle and queue the value expected after the next edge
    task automatic step(input logic e, input logic i, input logic s, input logic c,
                        input logic l, input logic [W-1:0] lv,
                        input logic [W-1:0] ec, input logic etc, input logic eerr);
        @(negedge clk);
        en = e; inc = i; sat = s; clr = c; load = l; load_val = lv;
        exp_q.push_back({ec, gray_of(ec), etc, eerr});
    endtask

    // Monitor / scoreboard
    initial begin
        logic [2*W+1:0] e;
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({cnt, gray, tc, err} !== e) begin
                    n_miss++;
                    $display("FAIL vec%0d: got cnt=%0d gray=%0d tc=%0b err=%0b, expected cnt=%0d gray=%0d tc=%0b err=%0b",
                             n_vec, cnt, gray, tc, err, e[2*W+1:W+2], e[W+1:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        n_vec = 0; n_miss = 0;
        en = 0; inc = 0; sat = 0; clr = 0; load = 0; load_val = '0;
        reset_n = 1'b0;
        #1;
        exp_q.push_back({3'd0, gray_of(3'd0), 1'b0, 1'b0});
        -> async_ev;
        #2 reset_n = 1'b1;

        // 1: count up with wrap
        step(1,1,0,0,0,0, 3'd1,0,0);
        step(1,1,0,0,0,0, 3'd2,0,0);
        step(1,1,0,0,0,0, 3'd3,0,0);
        step(1,1,0,0,0,0, 3'd4,0,0);
        step(1,1,0,0,0,0, 3'd0,1,0);
        step(1,1,0,0,0,0, 3'd1,0,0);
        // 2: count down with wrap
        step(1,0,0,0,0,0, 3'd0,0,0);
        step(1,0,0,0,0,0, 3'd4,1,0);
        step(1,0,0,0,0,0, 3'd3,0,0);
        // 3: saturate at top, then step down
        step(1,1,1,0,0,0, 3'd4,0,0);
        step(1,1,1,0,0,0, 3'd4,1,0);
        step(1,1,1,0,0,0, 3'd4,1,0);
        step(1,1,1,0,0,0, 3'd4,1,0);
        step(1,0,1,0,0,0, 3'd3,0,0);
        // 4: load, out-of-range load, sticky err, clear
        step(0,0,0,0,1,3'd2, 3'd2,0,0);
        step(0,0,0,0,1,3'd7, 3'd4,0,1);
        step(1,1,0,0,0,0,    3'd0,1,1);
        step(1,1,0,0,0,0,    3'd1,0,1);
        step(0,0,0,1,0,0,    3'd0,0,0);
        // 5: priority clr > load > en
        step(1,1,0,1,1,3'd3, 3'd0,0,0);
        step(1,1,0,0,1,3'd3, 3'd3,0,0);
        step(1,1,0,0,0,0,    3'd4,0,0);
        step(0,1,0,0,0,0,    3'd4,0,0);
        // Load boundaries: MOD-1 is legal, MOD is the first illegal value
        step(0,0,0,0,1,3'd4, 3'd4,0,0);
        step(0,0,0,0,1,3'd5, 3'd4,0,1);
        step(0,0,0,1,0,0,    3'd0,0,0);
        // 6: async reset mid-count with err set
        step(0,0,0,0,1,3'd6, 3'd4,0,1);
        step(1,0,0,0,0,0,    3'd3,0,1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        exp_q.push_back({3'd0, gray_of(3'd0), 1'b0, 1'b0});
        -> async_ev;
        #20 reset_n = 1'b1;
        step(1,1,0,0,0,0, 3'd1,0,0);
        // Saturate at the bottom bound
        step(1,0,1,0,0,0, 3'd0,0,0);
        step(1,0,1,0,0,0, 3'd0,1,0);
        step(0,0,0,0,0,0, 3'd0,0,0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expected values left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/cnt_mod_n.md
Name: cnt_mod_n

Overview:
Parametrised modulo-N up/down counter. It generalises the fixed 5-state up/down counter to any modulus and adds:
- count enable
- synchronous clear and parallel load
- selectable wrap or saturate mode
- terminal-count pulse, load-error flag and registered Gray-code output

It is the general-purpose sequence/state counter for datapath and FSM blocks in the design.

Parameters:
MOD, 5, number of count states; counter runs 0..MOD-1; legal range 2..2^WIDTH.
WIDTH, 3, count register width; must satisfy 2^WIDTH >= MOD.
RESET_VAL, 0, count value on reset and on clr; must be <= MOD-1.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  asynchronous active-low reset.
en  input  1  count enable; one step per clock while high.
inc  input  1  direction: 1 = up, 0 = down.
sat  input  1  bound mode: 1 = saturate, 0 = wrap.
clr  input  1  synchronous clear to RESET_VAL.
load  input  1  synchronous parallel load.
load_val  input  WIDTH  value to load.
cnt  output  WIDTH  current count, registered.
gray  output  WIDTH  Gray code of cnt, registered: gray = cnt ^ (cnt >> 1) in the same cycle.
tc  output  1  terminal-count pulse, registered.
err  output  1  sticky load-range error.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n). While reset_n = 0:
  - cnt = RESET_VAL
  - gray = Gray(RESET_VAL)
  - tc = 0, err = 0
  - Assertion takes effect immediately, without waiting for a clock edge.
  - Counting resumes on the first rising edge after deassertion.
- Per-edge priority, highest first: clr > load > en > hold.
- clr = 1:
  - cnt <= RESET_VAL, tc <= 0, err <= 0.
  - load and en are ignored that cycle.
- load = 1 (clr = 0):
  - If load_val <= MOD-1: cnt <= load_val.
  - Otherwise: cnt <= MOD-1 and err <= 1. err stays high until clr or reset.
  - tc <= 0.
  - en is ignored that cycle.
- en = 1 (clr = 0, load = 0):
  - Up, cnt < MOD-1: cnt <= cnt+1, tc <= 0.
  - Up, cnt == MOD-1: wrap mode gives cnt <= 0; sat mode holds MOD-1. tc <= 1 in both modes.
  - Down, cnt > 0: cnt <= cnt-1, tc <= 0.
  - Down, cnt == 0: wrap mode gives cnt <= MOD-1; sat mode holds 0. tc <= 1 in both modes.
- Idle (en = 0, no clr, no load): cnt holds, tc <= 0.
- tc duration:
  - tc is high for exactly the one cycle after a bound-crossing step.
  - Consecutive crossings (saturate mode at a bound with en held) keep tc high every cycle.
- Mode changes: inc and sat are sampled every edge and may change on any cycle; no pipeline or latency is involved.
- Latency: cnt, gray and tc all reflect a stimulus one edge later. gray always matches cnt in the same cycle.
- Range guarantee: cnt never leaves 0..MOD-1, even when MOD < 2^WIDTH.
- Arithmetic: modulo MOD, never modulo 2^WIDTH. No intermediate overflow is permitted, e.g. MOD = 2^WIDTH must wrap correctly.

Test Plan:
1. Reset and count-up wrap (MOD=5, sat=0): reset_n=0 at t=0, release at 3 ns, en=1, inc=1 -> cnt 0,1,2,3,4,0,1; tc=1 only in the cycle cnt shows 0 after 4; gray tracks 0,1,3,2,6,0.
2. Count-down wrap: from cnt=1, inc=0 -> cnt 0,4,3; tc=1 only in the cycle cnt shows 4.
3. Saturate: sat=1, inc=1 from cnt=3 for 4 cycles -> cnt 4,4,4,4; tc 0,1,1,1. Then inc=0 -> cnt 3, tc 0.
4. Load and error:
   - load=1, load_val=2 -> cnt=2, err=0.
   - load_val=7 -> cnt=4, err=1; err stays 1 through further counting.
   - clr=1 -> cnt=0, err=0.
5. Priority: clr=1, load=1, load_val=3, en=1 on the same edge -> cnt=0. Then load=1, en=1 -> cnt=3, no increment that cycle.
6. Async reset mid-count: drive reset_n=0 between edges while cnt=3 -> cnt=0, tc=0, err=0 immediately. Hold 20 ns; counting resumes from 0 on the first edge after release.
